// File: rtl/mash_dsm_pkg.sv
// Shared constants and helpers for the MASH 1-1-1 delta-sigma modulator.
package mash_dsm_pkg;

    localparam int LFSR_W      = 15;
    localparam int LFSR_TAP_HI = 14;
    localparam int LFSR_TAP_LO = 13;
    localparam int DSM_OUT_W   = 4;

    localparam logic [1:0] ORD1 = 2'd1;
    localparam logic [1:0] ORD2 = 2'd2;
    localparam logic [1:0] ORD3 = 2'd3;

    // x^15 + x^14 + 1, shifting left with the feedback entering bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state);
        return {state[LFSR_W-2:0], state[LFSR_TAP_HI] ^ state[LFSR_TAP_LO]};
    endfunction

    // An order select of 0 is treated as first order
    function automatic logic [1:0] norm_order(input logic [1:0] sel);
        logic [1:0] res;
        case (sel)
            2'd0:    res = ORD1;
            2'd1:    res = ORD1;
            2'd2:    res = ORD2;
            2'd3:    res = ORD3;
            default: res = ORD1;
        endcase
        return res;
    endfunction

    // Zero-extend a single carry into a signed output-width term
    function automatic logic signed [DSM_OUT_W-1:0] carry_term(input logic c);
        return $signed({{(DSM_OUT_W-1){1'b0}}, c});
    endfunction

endpackage

// File: rtl/mash_dsm_acc_stage.sv
// One MASH accumulator stage: registered W-bit accumulator with a
// combinational {carry,sum} of acc + addend + cin.
module dsm_acc_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] addend,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W-1:0] acc_r;
    logic [W:0]   total_s;

    // (W+1)-bit sum; the top bit is the stage overflow carry
    always_comb begin
        total_s = {1'b0, acc_r} + {1'b0, addend} + {{W{1'b0}}, cin};
    end

    assign sum   = total_s[W-1:0];
    assign carry = total_s[W];

    // Accumulator register: advances on enabled ticks, clears synchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {W{1'b0}};
        end else if (en) begin
            if (clr) begin
                acc_r <= {W{1'b0}};
            end else begin
                acc_r <= total_s[W-1:0];
            end
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/mash_dsm.sv
// MASH 1-1-1 delta-sigma modulator with run-time order select, LFSR dither
// and a handshaked fractional-word update; emits a signed divider offset.
module mash_dsm
    import mash_dsm_pkg::*;
#(
    parameter int                W         = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 15'h1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [1:0]   order_sel,
    input  logic         dither_en,
    input  logic [W-1:0] frac_in,
    input  logic         frac_ld,
    output logic         frac_ack,
    output logic [3:0]   dsm_out,
    output logic         out_valid
);

    logic [W-1:0]        frac_q_r;
    logic [1:0]          order_q_r;
    logic [LFSR_W-1:0]   lfsr_r;
    logic                c2_d_r;
    logic                c3_d_r;
    logic                c3_dd_r;
    logic [3:0]          dsm_out_r;
    logic                out_valid_r;
    logic                frac_ack_r;

    logic [1:0]          order_req_s;
    logic                order_chg_s;
    logic                dith_s;
    logic                load_s;
    logic [W-1:0]        s1_s;
    logic [W-1:0]        s2_s;
    logic [W-1:0]        s3_s;
    logic                c1_s;
    logic                c2_raw_s;
    logic                c3_raw_s;
    logic                c2_s;
    logic                c3_s;
    logic                c2_d_s;
    logic                c3_d_s;
    logic                c3_dd_s;
    logic signed [3:0]   y1_s;
    logic signed [3:0]   y2_s;
    logic signed [3:0]   y3_s;
    logic signed [3:0]   y_sel_s;

    // Control decode: order change detect, dither bit and load acceptance
    always_comb begin
        order_req_s = norm_order(order_sel);
        order_chg_s = (order_req_s != order_q_r);
        dith_s      = dither_en & lfsr_r[0];
        load_s      = frac_ld & en & ~frac_ack_r;
    end

    dsm_acc_stage #(.W(W)) u_stage1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (1'b0),
        .addend (frac_q_r),
        .cin    (dith_s),
        .sum    (s1_s),
        .carry  (c1_s)
    );

    dsm_acc_stage #(.W(W)) u_stage2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (order_chg_s),
        .addend (s1_s),
        .cin    (1'b0),
        .sum    (s2_s),
        .carry  (c2_raw_s)
    );

    dsm_acc_stage #(.W(W)) u_stage3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (order_chg_s),
        .addend (s2_s),
        .cin    (1'b0),
        .sum    (s3_s),
        .carry  (c3_raw_s)
    );

    // On an order switch stages 2/3 and their delay line count as already
    // cleared, so that tick's output carries first-stage content only.
    always_comb begin
        if (order_chg_s) begin
            c2_s    = 1'b0;
            c3_s    = 1'b0;
            c2_d_s  = 1'b0;
            c3_d_s  = 1'b0;
            c3_dd_s = 1'b0;
        end else begin
            c2_s    = c2_raw_s;
            c3_s    = c3_raw_s;
            c2_d_s  = c2_d_r;
            c3_d_s  = c3_d_r;
            c3_dd_s = c3_dd_r;
        end
    end

    // Noise-cancellation network and order select
    always_comb begin
        y1_s = carry_term(c1_s);
        y2_s = y1_s + carry_term(c2_s) - carry_term(c2_d_s);
        y3_s = y2_s + carry_term(c3_s) - (carry_term(c3_d_s) <<< 1) + carry_term(c3_dd_s);
        case (order_req_s)
            ORD1:    y_sel_s = y1_s;
            ORD2:    y_sel_s = y2_s;
            ORD3:    y_sel_s = y3_s;
            default: y_sel_s = y1_s;
        endcase
    end

    // Modulator state, carry delays, dither LFSR and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_q_r   <= ORD1;
            lfsr_r      <= LFSR_SEED;
            c2_d_r      <= 1'b0;
            c3_d_r      <= 1'b0;
            c3_dd_r     <= 1'b0;
            dsm_out_r   <= 4'd0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= en;
            if (en) begin
                order_q_r <= order_req_s;
                lfsr_r    <= lfsr_next(lfsr_r);
                c2_d_r    <= c2_s;
                c3_dd_r   <= c3_d_s;
                c3_d_r    <= c3_s;
                dsm_out_r <= y_sel_s;
            end else begin
                order_q_r <= order_q_r;
                lfsr_r    <= lfsr_r;
                c2_d_r    <= c2_d_r;
                c3_dd_r   <= c3_dd_r;
                c3_d_r    <= c3_d_r;
                dsm_out_r <= dsm_out_r;
            end
        end
    end

    // Fractional-word handshake; the captured word takes effect next tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_q_r   <= {W{1'b0}};
            frac_ack_r <= 1'b0;
        end else begin
            frac_ack_r <= load_s;
            if (load_s) begin
                frac_q_r <= frac_in;
            end else begin
                frac_q_r <= frac_q_r;
            end
        end
    end

    assign dsm_out   = dsm_out_r;
    assign out_valid = out_valid_r;
    assign frac_ack  = frac_ack_r;

endmodule

// File: tb/tb_mash_dsm.sv
// Directed self-checking bench for mash_dsm with a small behavioural model.
module tb_mash_dsm;

    localparam int          W    = 16;
    localparam logic [14:0] SEED = 15'h1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   order_sel;
    logic         dither_en;
    logic [W-1:0] frac_in;
    logic         frac_ld;
    logic         frac_ack;
    logic [3:0]   dsm_out;
    logic         out_valid;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] m_acc1, m_acc2, m_acc3, m_frac;
    logic         m_c2d, m_c3d, m_c3dd, m_ack;
    logic [14:0]  m_lfsr;
    logic [1:0]   m_order;
    int           m_out;

    mash_dsm #(.W(W), .LFSR_SEED(SEED)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .order_sel (order_sel),
        .dither_en (dither_en),
        .frac_in   (frac_in),
        .frac_ld   (frac_ld),
        .frac_ack  (frac_ack),
        .dsm_out   (dsm_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic int got_out();
        return int'($signed(dsm_out));
    endfunction

    task automatic model_reset();
        m_acc1 = '0; m_acc2 = '0; m_acc3 = '0; m_frac = '0;
        m_c2d = 1'b0; m_c3d = 1'b0; m_c3dd = 1'b0; m_ack = 1'b0;
        m_lfsr = SEED; m_order = 2'd1; m_out = 0;
    endtask

    // Behavioural reference for one clock, using the inputs about to be applied
    task automatic model_tick(input logic e);
        logic [W:0] t;
        logic       c1, c2, c3, chg, d;
        logic [1:0] on;
        int         y1, y2, y3;
        logic [W-1:0] old_frac;
        old_frac = m_frac;
        if (e) begin
            on  = (order_sel == 2'd0) ? 2'd1 : order_sel;
            chg = (on != m_order);
            if (chg) begin
                m_c2d = 1'b0; m_c3d = 1'b0; m_c3dd = 1'b0;
            end
            d = dither_en & m_lfsr[0];
            t = {1'b0, m_acc1} + {1'b0, old_frac} + {{W{1'b0}}, d};
            c1 = t[W]; m_acc1 = t[W-1:0];
            t = {1'b0, m_acc2} + {1'b0, m_acc1};
            c2 = t[W]; m_acc2 = t[W-1:0];
            t = {1'b0, m_acc3} + {1'b0, m_acc2};
            c3 = t[W]; m_acc3 = t[W-1:0];
            if (chg) begin
                c2 = 1'b0; c3 = 1'b0; m_acc2 = '0; m_acc3 = '0;
            end
            y1 = int'(c1);
            y2 = y1 + int'(c2) - int'(m_c2d);
            y3 = y2 + int'(c3) - 2 * int'(m_c3d) + int'(m_c3dd);
            m_out = (on == 2'd1) ? y1 : ((on == 2'd2) ? y2 : y3);
            m_c2d = c2; m_c3dd = m_c3d; m_c3d = c3;
            m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
            m_order = on;
        end
        if (frac_ld && e && !m_ack) begin
            m_frac = frac_in;
            m_ack  = 1'b1;
        end else begin
            m_ack = 1'b0;
        end
    endtask

    task automatic step(input logic e);
        en = e;
        model_tick(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; frac_ld = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; order_sel = 2'd1; dither_en = 1'b0;
        frac_in = '0; frac_ld = 1'b0;
        model_reset();
        #12;
        n_total++; if (dsm_out !== 4'd0) $display("FAIL reset_dsm_out got %0d exp 0", dsm_out); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", out_valid); else n_pass++;
        n_total++; if (frac_ack !== 1'b0) $display("FAIL reset_frac_ack got %0b exp 0", frac_ack); else n_pass++;
        n_total++; if (dut.lfsr_r !== SEED) $display("FAIL reset_lfsr got %h exp %h", dut.lfsr_r, SEED); else n_pass++;
        do_reset();
    endtask

    task automatic test_zero_frac();
        do_reset();
        order_sel = 2'd3; dither_en = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step(1'b1);
            n_total++;
            if (dsm_out !== 4'd0 || out_valid !== 1'b1)
                $display("FAIL zero_frac tick %0d got out=%0d valid=%0b exp out=0 valid=1", k, got_out(), out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_order1_half();
        do_reset();
        order_sel = 2'd1; dither_en = 1'b0;
        frac_in = 16'h8000; frac_ld = 1'b1;
        step(1'b1);
        n_total++; if (frac_ack !== 1'b1) $display("FAIL o1_ack got %0b exp 1", frac_ack); else n_pass++;
        n_total++; if (dsm_out !== 4'd0) $display("FAIL o1_load_tick got %0d exp 0", got_out()); else n_pass++;
        frac_ld = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(1'b1);
            n_total++;
            if (got_out() !== (k % 2)) $display("FAIL o1_pattern tick %0d got %0d exp %0d", k, got_out(), k % 2);
            else n_pass++;
        end
        n_total++; if (frac_ack !== 1'b0) $display("FAIL o1_ack_drop got %0b exp 0", frac_ack); else n_pass++;
    endtask

    task automatic test_order3_sum();
        int sum, mn, mx, bad, gaps, fg, fe;
        do_reset();
        order_sel = 2'd3; dither_en = 1'b0;
        frac_in = 16'h4000; frac_ld = 1'b1;
        step(1'b1);
        frac_ld = 1'b0;
        sum = 0; mn = 0; mx = 0; bad = 0; gaps = 0; fg = 0; fe = 0;
        for (int k = 0; k < 65536; k++) begin
            step(1'b1);
            sum += got_out();
            if (got_out() < mn) mn = got_out();
            if (got_out() > mx) mx = got_out();
            if (out_valid !== 1'b1) gaps++;
            if (got_out() != m_out) begin
                if (bad == 0) begin fg = got_out(); fe = m_out; end
                bad++;
            end
        end
        n_total++; if (sum != 16384) $display("FAIL o3_sum got %0d exp 16384", sum); else n_pass++;
        n_total++; if (mn < -3) $display("FAIL o3_min got %0d exp >=-3", mn); else n_pass++;
        n_total++; if (mx > 4) $display("FAIL o3_max got %0d exp <=4", mx); else n_pass++;
        n_total++; if (gaps != 0) $display("FAIL o3_valid_gaps got %0d exp 0", gaps); else n_pass++;
        n_total++; if (bad != 0) $display("FAIL o3_trace mismatches %0d first got %0d exp %0d", bad, fg, fe); else n_pass++;
    endtask

    task automatic test_stall();
        logic e;
        do_reset();
        order_sel = 2'd2; dither_en = 1'b1;
        frac_in = 16'h0ABC; frac_ld = 1'b1;
        step(1'b0);
        n_total++; if (frac_ack !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL stall_load got ack=%0b valid=%0b exp 0/0", frac_ack, out_valid); else n_pass++;
        step(1'b1);
        n_total++; if (frac_ack !== 1'b1) $display("FAIL stall_load_ack got %0b exp 1", frac_ack); else n_pass++;
        frac_ld = 1'b0;
        for (int k = 0; k < 60; k++) begin
            e = ((k % 3) != 1);
            if (k == 30) order_sel = 2'd0;
            if (k == 45) order_sel = 2'd3;
            step(e);
            n_total++;
            if (got_out() != m_out || out_valid !== e)
                $display("FAIL stall_seq cyc %0d got out=%0d valid=%0b exp out=%0d valid=%0b", k, got_out(), out_valid, m_out, e);
            else n_pass++;
        end
    endtask

    task automatic test_frac_update();
        logic exp_ack;
        int sum, bad;
        do_reset();
        order_sel = 2'd3; dither_en = 1'b0;
        frac_in = 16'h4000; frac_ld = 1'b1;
        step(1'b1);
        frac_ld = 1'b0;
        for (int k = 0; k < 200; k++) step(1'b1);
        frac_in = 16'h1000; frac_ld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            exp_ack = ((k % 2) == 0);
            n_total++;
            if (frac_ack !== exp_ack) $display("FAIL upd_ack cyc %0d got %0b exp %0b", k, frac_ack, exp_ack);
            else n_pass++;
        end
        frac_ld = 1'b0;
        n_total++; if (dut.frac_q_r !== 16'h1000) $display("FAIL upd_word got %h exp 1000", dut.frac_q_r); else n_pass++;
        sum = 0; bad = 0;
        for (int k = 0; k < 4096; k++) begin
            step(1'b1);
            sum += got_out();
            if (got_out() != m_out) bad++;
        end
        n_total++; if (sum < 253 || sum > 259) $display("FAIL upd_mean sum got %0d exp 256+-3", sum); else n_pass++;
        n_total++; if (bad != 0) $display("FAIL upd_trace got %0d mismatches exp 0", bad); else n_pass++;
    endtask

    task automatic test_switch_reset();
        int bad;
        do_reset();
        order_sel = 2'd3; dither_en = 1'b1;
        frac_in = 16'h1357; frac_ld = 1'b1;
        step(1'b1);
        frac_ld = 1'b0;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            step(1'b1);
            if (got_out() != m_out) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL sw_pre_trace got %0d mismatches exp 0", bad); else n_pass++;
        order_sel = 2'd2;
        step(1'b1);
        n_total++; if (dut.u_stage2.acc_r !== 16'h0 || dut.u_stage3.acc_r !== 16'h0)
            $display("FAIL sw_acc_clear got %h/%h exp 0/0", dut.u_stage2.acc_r, dut.u_stage3.acc_r); else n_pass++;
        n_total++; if ({dut.c2_d_r, dut.c3_d_r, dut.c3_dd_r} !== 3'b000)
            $display("FAIL sw_delay_clear got %b exp 000", {dut.c2_d_r, dut.c3_d_r, dut.c3_dd_r}); else n_pass++;
        n_total++; if (got_out() != m_out) $display("FAIL sw_tick got %0d exp %0d", got_out(), m_out); else n_pass++;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            step(1'b1);
            if (got_out() != m_out) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL sw_post_trace got %0d mismatches exp 0", bad); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (dsm_out !== 4'd0 || out_valid !== 1'b0 || frac_ack !== 1'b0)
            $display("FAIL async_rst_out got out=%0d valid=%0b ack=%0b exp 0/0/0", got_out(), out_valid, frac_ack); else n_pass++;
        n_total++; if (dut.lfsr_r !== SEED) $display("FAIL async_rst_lfsr got %h exp %h", dut.lfsr_r, SEED); else n_pass++;
        n_total++; if (dut.u_stage1.acc_r !== 16'h0 || dut.frac_q_r !== 16'h0)
            $display("FAIL async_rst_state got %h/%h exp 0/0", dut.u_stage1.acc_r, dut.frac_q_r); else n_pass++;
        do_reset();
        step(1'b0);
        n_total++; if (dsm_out !== 4'd0 || out_valid !== 1'b0)
            $display("FAIL post_rst_idle got out=%0d valid=%0b exp 0/0", got_out(), out_valid); else n_pass++;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1);
            if (got_out() != m_out || out_valid !== 1'b1) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL post_rst_trace got %0d mismatches exp 0", bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_frac();
        test_order1_half();
        test_order3_sum();
        test_stall();
        test_frac_update();
        test_switch_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
